vga_timing_ctrl: RTL and testbench
==================================

Name: vga_timing_ctrl

Overview:
Run-time configuration sequencer for the VESA timing core. It holds a shadow bank of timing registers that a host writes over a simple register port. On commit, it validates the bank and waits for the current frame to end. It then holds the timing core in reset, applies the new timing to the core's static inputs, and releases reset so the core restarts cleanly in the new mode.

Parameters:
RST_CYCLES, 16, pxl_clk cycles core_rst is held asserted per mode change (legal range 1..255)
FRAME_TIMEOUT, 2000000, pxl_clk cycles to wait for a frame boundary before forcing the change
DEF_HRES/DEF_HFP/DEF_HBP/DEF_HSW, 640/16/48/96, reset horizontal timing
DEF_VRES/DEF_VFP/DEF_VBP/DEF_VSW, 480/10/33/2, reset vertical timing
DEF_HPOL/DEF_VPOL, 0/0, reset sync polarities

Ports:
pxl_clk  in  1  pixel clock; the only clock in the block
pxl_rst_n  in  1  asynchronous, active-low reset
cfg_wr  in  1  shadow register write strobe, one cycle
cfg_addr  in  4  0 hoz_res, 1 hoz_front, 2 hoz_back, 3 hoz_sync_len, 4 vert_res, 5 vert_front, 6 vert_back, 7 vert_sync_len, 8 polarity (bit0 hsync_pol, bit1 vsync_pol)
cfg_wdata  in  32  write data
cfg_commit  in  1  request to apply the shadow bank, one-cycle pulse
cfg_busy  out  1  mode change in progress
cfg_err  out  1  one-cycle error pulse
vsync_in  in  1  vsync from the timing core, synchronous to pxl_clk
hoz_res, hoz_front, hoz_back, hoz_sync_len  out  32 each  active horizontal timing to the core
vert_res, vert_front, vert_back, vert_sync_len  out  32 each  active vertical timing to the core
hsync_pol, vsync_pol  out  1 each  active polarities to the core
core_rst  out  1  active-high reset to the timing core

Behaviour:
- Reset (pxl_rst_n low, async):
  - shadow and active registers load the DEF_* values
  - core_rst=1, cfg_busy=1, cfg_err=0
  - state=HOLD, hold counter=0
- State machine:
  - RUN: core_rst=0, cfg_busy=0.
    - cfg_wr with cfg_addr<=8 updates that shadow register on the next edge. For addr 8 only bits[1:0] are stored.
    - cfg_wr with cfg_addr>8: no write, cfg_err pulses.
    - cfg_commit, valid bank: go to WAIT_FRAME; cfg_busy=1 from the next cycle.
    - cfg_commit, invalid bank (any of hoz_res, hoz_sync_len, vert_res, vert_sync_len == 0): cfg_err pulses, stay in RUN, active registers unchanged.
    - cfg_wr and cfg_commit in the same cycle: the write lands first, then validation uses the post-write bank.
  - WAIT_FRAME: vsync_in is registered once internally. Leave this state on the first cycle the registered vsync_in shows a transition into the active level, where active level = current active vsync_pol. Also leave when the timeout counter reaches FRAME_TIMEOUT-1. On exit, go to HOLD.
  - HOLD:
    - Entry cycle: active registers are copied from the shadow bank, core_rst=1, hold counter cleared. The core therefore only sees new values while held in reset.
    - After RST_CYCLES cycles in HOLD: core_rst=0 and cfg_busy=0 in the same cycle, next state RUN.
    - After reset, the first HOLD uses the DEF_* values and needs no commit.
- In WAIT_FRAME or HOLD, cfg_wr and cfg_commit are ignored; each attempt pulses cfg_err. The shadow bank is unchanged.
- Register widths: all timing registers are 32 bits and stored verbatim; no arithmetic is done on them.
- Counters: the timeout counter is 32 bits and the hold counter is 8 bits. Both saturate and never wrap.
- core_rst is a registered output, glitch-free.
- pxl_rst_n asserted mid-operation aborts any sequence. All state returns to the reset values above.

Test Plan:
- Release pxl_rst_n: core_rst stays 1 for exactly 16 cycles, then 0. Outputs read 640/16/48/96/480/10/33/2 and pol=0/0. cfg_busy falls in the same cycle as core_rst.
- Write 800/40/88/128/600/1/23/4 and pol=3, then commit. Outputs hold their old values until the vsync_in active edge (+1 cycle register delay). Then core_rst=1 for 16 cycles with the new values present, and cfg_busy spans commit+1 through core_rst fall.
- Write hoz_res=0, then commit: a single cfg_err pulse, cfg_busy stays 0, active outputs unchanged, core_rst stays 0.
- Commit with vsync_in held constant: the change is forced after exactly FRAME_TIMEOUT cycles (set to 100 in the bench), followed by the normal HOLD.
- During WAIT_FRAME, cfg_wr addr 0 = 1024 and a second commit: two cfg_err pulses, and the applied hoz_res is the value written before the first commit.
- Assert pxl_rst_n low in the middle of HOLD: outputs return to DEF_* at once, core_rst=1, and the sequence restarts with a full 16-cycle hold.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// ----------------------------------------------------------------------------
// vga_timing_ctrl
//   Run-time mode-change sequencer for the VESA timing core. A host fills a
//   shadow bank of timing registers. On commit the bank is validated. The
//   sequencer then waits for the end of the current frame, holds the core in
//   reset, applies the new timing to the core's static inputs and releases
//   reset, so the core restarts cleanly in the new mode.
//
// Ports
//   pxl_clk, pxl_rst_n      pixel clock, async active-low reset
//   cfg_wr/addr/wdata       shadow register write port
//                           addr 0..7 = timing, addr 8 = {vsync_pol, hsync_pol}
//   cfg_commit              request to apply the shadow bank (one-cycle pulse)
//   cfg_busy                mode change in progress
//   cfg_err                 one-cycle pulse: bad address, invalid bank, or
//                           access attempted while busy
//   vsync_in                vsync from the timing core (pxl_clk domain)
//   hoz_* / vert_* / *_pol  active timing to the core (static while it runs)
//   core_rst                registered active-high reset to the timing core
//
// State table
//   ST_RUN        | core running; shadow bank writable; commit accepted
//   ST_WAIT_FRAME | commit accepted; waiting for a vsync active edge or timeout
//   ST_HOLD       | core held in reset with the new timing for RST_CYCLES
// ----------------------------------------------------------------------------
module vga_timing_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned FRAME_TIMEOUT = 2000000,
  parameter logic [31:0] DEF_HRES      = 32'd640,
  parameter logic [31:0] DEF_HFP       = 32'd16,
  parameter logic [31:0] DEF_HBP       = 32'd48,
  parameter logic [31:0] DEF_HSW       = 32'd96,
  parameter logic [31:0] DEF_VRES      = 32'd480,
  parameter logic [31:0] DEF_VFP       = 32'd10,
  parameter logic [31:0] DEF_VBP       = 32'd33,
  parameter logic [31:0] DEF_VSW       = 32'd2,
  parameter logic        DEF_HPOL      = 1'b0,
  parameter logic        DEF_VPOL      = 1'b0
) (
  input  logic        pxl_clk,
  input  logic        pxl_rst_n,
  input  logic        cfg_wr,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic        cfg_commit,
  output logic        cfg_busy,
  output logic        cfg_err,
  input  logic        vsync_in,
  output logic [31:0] hoz_res,
  output logic [31:0] hoz_front,
  output logic [31:0] hoz_back,
  output logic [31:0] hoz_sync_len,
  output logic [31:0] vert_res,
  output logic [31:0] vert_front,
  output logic [31:0] vert_back,
  output logic [31:0] vert_sync_len,
  output logic        hsync_pol,
  output logic        vsync_pol,
  output logic        core_rst
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_HOLD       = 2'd2
  } state_t;

  // Bank index 0 is hoz_res, matching the register address map.
  localparam logic [7:0][31:0] DEF_TIMING = {DEF_VSW, DEF_VBP, DEF_VFP, DEF_VRES,
                                             DEF_HSW, DEF_HBP, DEF_HFP, DEF_HRES};
  localparam logic [1:0]       DEF_POL    = {DEF_VPOL, DEF_HPOL};
  localparam logic [31:0]      TMO_LAST   = 32'(FRAME_TIMEOUT - 1);
  localparam logic [7:0]       HOLD_LAST  = 8'(RST_CYCLES - 1);

  state_t            state_q, state_d;
  logic [7:0][31:0]  shadow_q, shadow_d;
  logic [7:0][31:0]  act_q, act_d;
  logic [1:0]        shadow_pol_q, shadow_pol_d;
  logic [1:0]        act_pol_q, act_pol_d;
  logic [7:0]        hold_cnt_q, hold_cnt_d;
  logic [31:0]       tmo_cnt_q, tmo_cnt_d;
  logic              core_rst_q, core_rst_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              vsync_q, vsync_prev_q;
  logic              frame_edge;

  // Frame boundary: registered vsync just entered the currently active level.
  assign frame_edge = (vsync_q == act_pol_q[1]) && (vsync_prev_q != act_pol_q[1]);

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    shadow_pol_d = shadow_pol_q;
    act_d        = act_q;
    act_pol_d    = act_pol_q;
    hold_cnt_d   = hold_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    core_rst_d   = core_rst_q;
    busy_d       = busy_q;
    err_d        = 1'b0;

    case (state_q)
      ST_RUN: begin
        core_rst_d = 1'b0;
        busy_d     = 1'b0;
        if (cfg_wr) begin
          if (cfg_addr <= 4'd7) begin
            shadow_d[cfg_addr[2:0]] = cfg_wdata;
          end else if (cfg_addr == 4'd8) begin
            shadow_pol_d = cfg_wdata[1:0];
          end else begin
            err_d = 1'b1;
          end
        end
        // Validation looks at the bank including a write in the same cycle.
        if (cfg_commit) begin
          if ((shadow_d[0] != 32'd0) && (shadow_d[3] != 32'd0) &&
              (shadow_d[4] != 32'd0) && (shadow_d[7] != 32'd0)) begin
            state_d   = ST_WAIT_FRAME;
            busy_d    = 1'b1;
            tmo_cnt_d = 32'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_WAIT_FRAME: begin
        busy_d = 1'b1;
        if (cfg_wr || cfg_commit) err_d = 1'b1;
        if (tmo_cnt_q != 32'hFFFF_FFFF) tmo_cnt_d = tmo_cnt_q + 32'd1;
        if (frame_edge || (tmo_cnt_q >= TMO_LAST)) begin
          // New timing reaches the core only together with its reset.
          state_d    = ST_HOLD;
          act_d      = shadow_q;
          act_pol_d  = shadow_pol_q;
          core_rst_d = 1'b1;
          hold_cnt_d = 8'd0;
        end
      end

      ST_HOLD: begin
        core_rst_d = 1'b1;
        busy_d     = 1'b1;
        if (cfg_wr || cfg_commit) err_d = 1'b1;
        if (hold_cnt_q >= HOLD_LAST) begin
          state_d    = ST_RUN;
          core_rst_d = 1'b0;
          busy_d     = 1'b0;
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d    = ST_HOLD;
        core_rst_d = 1'b1;
        busy_d     = 1'b1;
        hold_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge pxl_clk or negedge pxl_rst_n) begin
    if (!pxl_rst_n) begin
      state_q      <= ST_HOLD;
      shadow_q     <= DEF_TIMING;
      shadow_pol_q <= DEF_POL;
      act_q        <= DEF_TIMING;
      act_pol_q    <= DEF_POL;
      hold_cnt_q   <= 8'd0;
      tmo_cnt_q    <= 32'd0;
      core_rst_q   <= 1'b1;
      busy_q       <= 1'b1;
      err_q        <= 1'b0;
      vsync_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      shadow_pol_q <= shadow_pol_d;
      act_q        <= act_d;
      act_pol_q    <= act_pol_d;
      hold_cnt_q   <= hold_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      core_rst_q   <= core_rst_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      vsync_q      <= vsync_in;
      vsync_prev_q <= vsync_q;
    end
  end

  assign hoz_res       = act_q[0];
  assign hoz_front     = act_q[1];
  assign hoz_back      = act_q[2];
  assign hoz_sync_len  = act_q[3];
  assign vert_res      = act_q[4];
  assign vert_front    = act_q[5];
  assign vert_back     = act_q[6];
  assign vert_sync_len = act_q[7];
  assign hsync_pol     = act_pol_q[0];
  assign vsync_pol     = act_pol_q[1];
  assign core_rst      = core_rst_q;
  assign cfg_busy      = busy_q;
  assign cfg_err       = err_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_ctrl
//   Self-checking bench for vga_timing_ctrl. A bench-side model of the shadow
//   and active banks produces expected values, which are queued when stimulus
//   is driven and popped for comparison once the DUT shows its response.
//   Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_vga_timing_ctrl;

  localparam int RST_CYC = 16;
  localparam int TMO     = 100;

  logic        pxl_clk    = 1'b0;
  logic        pxl_rst_n  = 1'b0;
  logic        cfg_wr     = 1'b0;
  logic [3:0]  cfg_addr   = 4'd0;
  logic [31:0] cfg_wdata  = 32'd0;
  logic        cfg_commit = 1'b0;
  logic        vsync_in   = 1'b1;
  logic        cfg_busy, cfg_err, hsync_pol, vsync_pol, core_rst;
  logic [31:0] hoz_res, hoz_front, hoz_back, hoz_sync_len;
  logic [31:0] vert_res, vert_front, vert_back, vert_sync_len;

  always #5 pxl_clk = ~pxl_clk;

  vga_timing_ctrl #(.RST_CYCLES(RST_CYC), .FRAME_TIMEOUT(TMO)) dut (
    .pxl_clk(pxl_clk), .pxl_rst_n(pxl_rst_n),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .vsync_in(vsync_in),
    .hoz_res(hoz_res), .hoz_front(hoz_front), .hoz_back(hoz_back),
    .hoz_sync_len(hoz_sync_len),
    .vert_res(vert_res), .vert_front(vert_front), .vert_back(vert_back),
    .vert_sync_len(vert_sync_len),
    .hsync_pol(hsync_pol), .vsync_pol(vsync_pol), .core_rst(core_rst)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int err_seen = 0;

  logic [31:0] def_bank [0:8] = '{640, 16, 48, 96, 480, 10, 33, 2, 0};
  logic [31:0] m_sh  [0:8];
  logic [31:0] m_act [0:8];

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_chk(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_underflow", obs, ~obs);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  function automatic logic [31:0] obs_reg(input int i);
    case (i)
      0: return hoz_res;
      1: return hoz_front;
      2: return hoz_back;
      3: return hoz_sync_len;
      4: return vert_res;
      5: return vert_front;
      6: return vert_back;
      7: return vert_sync_len;
      default: return {30'd0, vsync_pol, hsync_pol};
    endcase
  endfunction

  // One clock: wait for the falling edge and tally any error pulse seen there.
  task automatic cyc();
    @(negedge pxl_clk);
    if (cfg_err === 1'b1) err_seen++;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input bit accepted);
    cfg_wr    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    cyc();
    cfg_wr = 1'b0;
    if (accepted && a <= 4'd8) m_sh[a] = (a == 4'd8) ? (d & 32'd3) : d;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    cyc();
    cfg_commit = 1'b0;
  endtask

  task automatic push_active(input string pfx);
    for (int i = 0; i <= 8; i++) sb_push($sformatf("%s_reg%0d", pfx, i), m_act[i]);
  endtask

  task automatic pop_active();
    for (int i = 0; i <= 8; i++) sb_pop_chk(obs_reg(i));
  endtask

  task automatic apply_model();
    for (int i = 0; i <= 8; i++) m_act[i] = m_sh[i];
  endtask

  task automatic reset_model();
    for (int i = 0; i <= 8; i++) begin
      m_sh[i]  = def_bank[i];
      m_act[i] = def_bank[i];
    end
  endtask

  // Negedges until core_rst rises (bounded).
  task automatic wait_rst_rise(output int n);
    n = 0;
    while (core_rst !== 1'b1 && n < 500) begin
      cyc();
      n++;
    end
  endtask

  // Samples while core_rst is high, counting those where busy was not also high.
  task automatic hold_len(output int n, output int busy_bad);
    n = 0;
    busy_bad = 0;
    while (core_rst === 1'b1 && n < 500) begin
      if (cfg_busy !== 1'b1) busy_bad++;
      n++;
      cyc();
    end
  endtask

  // Hold phase: queue expectations, then observe length and busy alignment.
  task automatic check_hold(input string tag);
    int n, bb;
    sb_push({tag, "_hold_len"}, RST_CYC);
    sb_push({tag, "_busy_in_hold"}, 0);
    sb_push({tag, "_busy_after"}, 0);
    hold_len(n, bb);
    sb_pop_chk(n);
    sb_pop_chk(bb);
    sb_pop_chk(cfg_busy);
  endtask

  initial begin
    int n;
    reset_model();

    // ---- reset state and first hold with defaults ----
    cyc();
    cyc();
    sb_push("rst_core_rst", 1);
    sb_push("rst_busy", 1);
    sb_push("rst_err", 0);
    push_active("rst");
    sb_pop_chk(core_rst);
    sb_pop_chk(cfg_busy);
    sb_pop_chk(cfg_err);
    pop_active();
    pxl_rst_n = 1'b1;
    check_hold("boot");

    // ---- new mode applied on vsync active edge (active level 0) ----
    wr(0, 800, 1); wr(1, 40, 1); wr(2, 88, 1); wr(3, 128, 1);
    wr(4, 600, 1); wr(5, 1, 1);  wr(6, 23, 1); wr(7, 4, 1);
    wr(8, 3, 1);
    commit();
    sb_push("busy_after_commit", 1);
    sb_pop_chk(cfg_busy);
    for (int i = 0; i < 5; i++) cyc();
    push_active("wait_old");
    sb_push("wait_core_rst", 0);
    pop_active();
    sb_pop_chk(core_rst);
    vsync_in = 1'b0;
    sb_push("vsync_to_core_rst", 2);
    wait_rst_rise(n);
    sb_pop_chk(n);
    apply_model();
    push_active("mode1");
    pop_active();
    check_hold("mode1");

    // ---- invalid bank and bad address ----
    err_seen = 0;
    wr(0, 0, 1);
    commit();
    cyc(); cyc(); cyc();
    sb_push("invalid_err_pulses", 1);
    sb_push("invalid_busy", 0);
    sb_push("invalid_core_rst", 0);
    sb_push("invalid_hoz_res", m_act[0]);
    sb_pop_chk(err_seen);
    sb_pop_chk(cfg_busy);
    sb_pop_chk(core_rst);
    sb_pop_chk(hoz_res);
    wr(0, 800, 1);
    err_seen = 0;
    wr(9, 55, 1);
    cyc();
    sb_push("badaddr_err_pulses", 1);
    sb_pop_chk(err_seen);

    // ---- forced change on timeout (vsync constant) ----
    wr(1, 20, 1);
    commit();
    sb_push("timeout_latency", TMO);
    wait_rst_rise(n);
    sb_pop_chk(n);
    apply_model();
    push_active("tmo");
    pop_active();
    check_hold("tmo");

    // ---- accesses while busy are refused ----
    wr(0, 1280, 1);
    commit();
    err_seen = 0;
    cyc();
    wr(0, 1024, 0);
    cyc();
    cyc();
    commit();
    cyc();
    sb_push("busy_access_err_pulses", 2);
    sb_pop_chk(err_seen);
    vsync_in = 1'b1;
    sb_push("vsync_hi_to_core_rst", 2);
    wait_rst_rise(n);
    sb_pop_chk(n);
    apply_model();
    push_active("busyacc");
    pop_active();
    check_hold("busyacc");

    // ---- reset in the middle of a hold ----
    wr(2, 99, 1);
    commit();
    wait_rst_rise(n);
    for (int i = 0; i < 5; i++) cyc();
    sb_push("midhold_hoz_back", 99);
    sb_pop_chk(hoz_back);
    pxl_rst_n = 1'b0;
    #1;
    reset_model();
    push_active("abort");
    sb_push("abort_core_rst", 1);
    sb_push("abort_busy", 1);
    pop_active();
    sb_pop_chk(core_rst);
    sb_pop_chk(cfg_busy);
    cyc();
    pxl_rst_n = 1'b1;
    check_hold("restart");

    // Shadow bank also returned to defaults: an unmodified commit applies them.
    commit();
    wait_rst_rise(n);
    push_active("post_abort");
    pop_active();
    check_hold("post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
